button_conditioner: RTL and testbench

Conditions the four raw board push-buttons into the single-cycle command pulses consumed by player (left, right, shoot, start). Each button gets a 2-flop synchroniser and a debounce filter. shoot and start become rising-edge pulses. left and right get press-then-auto-repeat pulses, so a held button keeps the ship moving. The block sits directly upstream of player in the top level.

---
 rtl/game_pkg.sv | 23 ++
 rtl/button_debouncer.sv | 46 ++++
 rtl/button_conditioner.sv | 156 +++++++++++++++
 tb/tb_button_conditioner.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game definitions: move FSM encodings, direction encoding and default
// input-conditioning timing at a 25 MHz system clock.
package game_pkg;

  typedef enum logic [1:0] {
    MvIdle,
    MvDelay,
    MvRepeat
  } move_state_e;

  typedef enum logic {
    DirLeft  = 1'b0,
    DirRight = 1'b1
  } dir_e;

  // 10 ms debounce window
  localparam int unsigned DefDebounceCycles = 250000;
  // 200 ms from the first move pulse to the first auto-repeat
  localparam int unsigned DefRepeatDelay    = 5000000;
  // 100 ms between subsequent auto-repeats
  localparam int unsigned DefRepeatPeriod   = 2500000;

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser followed by a consecutive-cycle debounce filter for one
// raw asynchronous push-button.
module button_debouncer
  import game_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic            r_meta;
  logic            r_sync;
  logic            r_db;
  logic [CntW-1:0] r_cnt;

  // Synchronise the raw input, then flip the stable state only after the
  // synchronised value has disagreed with it for DEBOUNCE_CYCLES cycles in a row.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_db   <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_meta <= raw;
      r_sync <= r_meta;
      if (r_sync == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == CntLast) begin
        r_db  <= r_sync;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CntW'(1);
      end
    end
  end

  assign stable = r_db;

endmodule

// File: rtl/button_conditioner.sv
// Turns the four raw board buttons into single-cycle player commands: shoot and
// start fire once per press, left and right fire on press and then auto-repeat.
module button_conditioner
  import game_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
  parameter int unsigned REPEAT_DELAY    = DefRepeatDelay,
  parameter int unsigned REPEAT_PERIOD   = DefRepeatPeriod
) (
  input  logic clk,
  input  logic reset,
  input  logic btnLeft,
  input  logic btnRight,
  input  logic btnShoot,
  input  logic btnStart,
  output logic left,
  output logic right,
  output logic shoot,
  output logic start
);

  // One timer serves both the initial delay and the repeat period.
  localparam int unsigned TmrMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned TmrW   = $clog2(TmrMax);
  localparam logic [TmrW-1:0] DelayLast  = TmrW'(REPEAT_DELAY - 1);
  localparam logic [TmrW-1:0] PeriodLast = TmrW'(REPEAT_PERIOD - 1);

  logic w_db_left;
  logic w_db_right;
  logic w_db_shoot;
  logic w_db_start;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
    .clk    (clk),
    .reset  (reset),
    .raw    (btnLeft),
    .stable (w_db_left)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
    .clk    (clk),
    .reset  (reset),
    .raw    (btnRight),
    .stable (w_db_right)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_shoot (
    .clk    (clk),
    .reset  (reset),
    .raw    (btnShoot),
    .stable (w_db_shoot)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
    .clk    (clk),
    .reset  (reset),
    .raw    (btnStart),
    .stable (w_db_start)
  );

  logic r_shoot_prev;
  logic r_start_prev;
  logic r_shoot;
  logic r_start;

  // Rising-edge pulses on the debounced fire and start buttons.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_shoot_prev <= 1'b0;
      r_start_prev <= 1'b0;
      r_shoot      <= 1'b0;
      r_start      <= 1'b0;
    end else begin
      r_shoot_prev <= w_db_shoot;
      r_start_prev <= w_db_start;
      r_shoot      <= w_db_shoot & ~r_shoot_prev;
      r_start      <= w_db_start & ~r_start_prev;
    end
  end

  // Holding both directions cancels movement.
  logic w_eff_l;
  logic w_eff_r;
  logic w_dir_held;

  assign w_eff_l    = w_db_left & ~w_db_right;
  assign w_eff_r    = w_db_right & ~w_db_left;

  move_state_e     r_state;
  dir_e            r_dir;
  logic [TmrW-1:0] r_timer;
  logic            r_left;
  logic            r_right;

  assign w_dir_held = (r_dir == DirLeft) ? w_eff_l : w_eff_r;

  // Move FSM: pulse on press, wait REPEAT_DELAY, then pulse every REPEAT_PERIOD
  // until the latched direction is no longer the effective direction.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= MvIdle;
      r_dir   <= DirLeft;
      r_timer <= '0;
      r_left  <= 1'b0;
      r_right <= 1'b0;
    end else begin
      r_left  <= 1'b0;
      r_right <= 1'b0;
      unique case (r_state)
        MvIdle: begin
          if (w_eff_l) begin
            r_left  <= 1'b1;
            r_dir   <= DirLeft;
            r_timer <= '0;
            r_state <= MvDelay;
          end else if (w_eff_r) begin
            r_right <= 1'b1;
            r_dir   <= DirRight;
            r_timer <= '0;
            r_state <= MvDelay;
          end
        end
        MvDelay: begin
          if (!w_dir_held) begin
            r_state <= MvIdle;
          end else if (r_timer == DelayLast) begin
            r_left  <= (r_dir == DirLeft);
            r_right <= (r_dir == DirRight);
            r_timer <= '0;
            r_state <= MvRepeat;
          end else begin
            r_timer <= r_timer + TmrW'(1);
          end
        end
        MvRepeat: begin
          if (!w_dir_held) begin
            r_state <= MvIdle;
          end else if (r_timer == PeriodLast) begin
            r_left  <= (r_dir == DirLeft);
            r_right <= (r_dir == DirRight);
            r_timer <= '0;
          end else begin
            r_timer <= r_timer + TmrW'(1);
          end
        end
        default: r_state <= MvIdle;
      endcase
    end
  end

  assign left  = r_left;
  assign right = r_right;
  assign shoot = r_shoot;
  assign start = r_start;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner with short timing parameters.
// Inputs change on the falling edge; if a button changes at the negedge where
// cyc==base, the DUT output seen at the negedge where cyc==base+n is the pulse
// labelled t=n in the timing plan.
module tb_button_conditioner;

  logic clk;
  logic reset;
  logic btnLeft, btnRight, btnShoot, btnStart;
  logic left, right, shoot, start;

  button_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (6),
    .REPEAT_PERIOD   (3)
  ) u_dut (
    .clk      (clk),
    .reset    (reset),
    .btnLeft  (btnLeft),
    .btnRight (btnRight),
    .btnShoot (btnShoot),
    .btnStart (btnStart),
    .left     (left),
    .right    (right),
    .shoot    (shoot),
    .start    (start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output vector ordering: {left, right, shoot, start}
  localparam logic [3:0] OL = 4'b1000;
  localparam logic [3:0] OR = 4'b0100;
  localparam logic [3:0] OS = 4'b0010;
  localparam logic [3:0] OT = 4'b0001;

  typedef struct packed {
    int unsigned cyc;
    logic [3:0]  outs;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic expect_pulse(input int unsigned at, input logic [3:0] o);
    exp_t e;
    e.cyc  = at;
    e.outs = o;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_zero(input string name);
    vectors++;
    if ({left, right, shoot, start} !== 4'b0000) begin
      miscompares++;
      $display("FAIL %s: outs=%b at cyc %0d, required 0000", name,
               {left, right, shoot, start}, cyc);
    end
  endtask

  // Monitor: any nonzero output must match the oldest pending expectation.
  always @(negedge clk) begin : mon
    exp_t       e;
    logic [3:0] o;
    o = {left, right, shoot, start};
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL missed_pulse: got nothing, required outs=%b at cyc %0d", e.outs, e.cyc);
    end
    if (o !== 4'b0000) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_pulse: got outs=%b at cyc %0d, required none", o, cyc);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.outs !== o) begin
          miscompares++;
          $display("FAIL pulse: got outs=%b at cyc %0d, required outs=%b at cyc %0d",
                   o, cyc, e.outs, e.cyc);
        end
      end
    end
  end

  initial begin
    int unsigned base;
    int unsigned m;
    reset    = 1'b0;
    btnLeft  = 1'b0;
    btnRight = 1'b0;
    btnShoot = 1'b0;
    btnStart = 1'b0;

    repeat (3) begin
      @(negedge clk);
      check_zero("reset_state");
    end
    reset = 1'b1;
    idle(5);

    // Shoot held 10 cycles: one pulse at t=7, nothing on release.
    base = cyc;
    btnShoot = 1'b1;
    expect_pulse(base + 7, OS);
    idle(10);
    btnShoot = 1'b0;
    idle(15);

    // Left glitch of 3 cycles: shorter than the debounce window, no pulse.
    btnLeft = 1'b1;
    idle(3);
    btnLeft = 1'b0;
    idle(15);

    // Right held 27 cycles: press pulse, first repeat after 6, then every 3.
    // Debounced release lands before the t=34 repeat, so 31 is the last pulse.
    base = cyc;
    btnRight = 1'b1;
    expect_pulse(base + 7, OR);
    for (int t = 13; t <= 31; t += 3) expect_pulse(base + t, OR);
    idle(27);
    btnRight = 0;
    idle(20);

    // Both held: no movement. Dropping right yields one left pulse.
    btnLeft  = 1'b1;
    btnRight = 1'b1;
    idle(20);
    base = cyc;
    btnRight = 1'b0;
    expect_pulse(base + 7, OL);
    idle(6);
    btnLeft = 1'b0;
    idle(20);

    // Right held through a 2-cycle reset while repeating.
    base = cyc;
    btnRight = 1'b1;
    expect_pulse(base + 7, OR);
    expect_pulse(base + 13, OR);
    expect_pulse(base + 16, OR);
    idle(17);
    reset = 1'b0;
    idle(1);
    check_zero("in_reset");
    idle(1);
    check_zero("in_reset");
    reset = 1'b1;
    m = cyc;
    expect_pulse(m + 7, OR);
    expect_pulse(m + 13, OR);
    expect_pulse(m + 16, OR);
    expect_pulse(m + 19, OR);
    expect_pulse(m + 22, OR);
    idle(17);
    btnRight = 1'b0;
    idle(20);

    // Shoot and start together pulse in the same cycle.
    base = cyc;
    btnShoot = 1'b1;
    btnStart = 1'b1;
    expect_pulse(base + 7, OS | OT);
    idle(10);
    btnShoot = 1'b0;
    btnStart = 1'b0;
    idle(15);

    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL missed_pulse: got nothing, required outs=%b at cyc %0d", e.outs, e.cyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
